// File: rtl/npu_pkg.sv
// Shared NPU definitions: default result width, signed minimum sentinel and
// the argmax feeder state type.
package npu_pkg;

  localparam int unsigned NPU_DATA_W = 16;
  localparam logic signed [NPU_DATA_W-1:0] NPU_NEG_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FINISH
  } feeder_state_e;

  // Pairs needed to cover n results; an odd count pads the final in2.
  function automatic int unsigned num_pairs(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/argmax_pair_feeder_if.sv
// Result-write, scan-control and comparator-feed signals of argmax_pair_feeder.
interface argmax_pair_feeder_if
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = NPU_DATA_W
);

  logic                     wr_en;
  logic [7:0]               wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     START;
  logic                     hold;
  logic                     EN_COMP;
  logic                     RST_COMP;
  logic                     trig;
  logic signed [DATA_W-1:0] in1;
  logic signed [DATA_W-1:0] in2;
  logic                     busy;
  logic                     DONE;

  modport master (
    output wr_en, wr_addr, wr_data, START, hold,
    input  EN_COMP, RST_COMP, trig, in1, in2, busy, DONE
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, START, hold,
    output EN_COMP, RST_COMP, trig, in1, in2, busy, DONE
  );

endinterface

// File: rtl/npu_result_buf.sv
// N_OUT x DATA_W result register file: one write port, two asynchronous read
// ports; reads beyond the last entry return the signed minimum.
module npu_result_buf
  import npu_pkg::*;
#(
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned DATA_W = NPU_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [7:0]               waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [7:0]               raddr_a,
  input  logic [7:0]               raddr_b,
  output logic signed [DATA_W-1:0] rdata_a,
  output logic signed [DATA_W-1:0] rdata_b
);

  localparam logic signed [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] mem [N_OUT];

  // Address decode by equality keeps out-of-range writes from touching any entry.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (waddr == 8'(i)) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata_a = NEG_MIN;
    rdata_b = NEG_MIN;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (raddr_a == 8'(i)) rdata_a = mem[i];
      if (raddr_b == 8'(i)) rdata_b = mem[i];
    end
  end

endmodule

// File: rtl/argmax_pair_feeder.sv
// Buffers the output-layer results and, on START, clears the argmax
// comparator then streams the results to it two per cycle.
module argmax_pair_feeder
  import npu_pkg::*;
#(
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned DATA_W = NPU_DATA_W
) (
  input logic                 CLKEXT,
  input logic                 RST,
  argmax_pair_feeder_if.slave bus
);

  localparam logic signed [DATA_W-1:0] NEG_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [7:0]               NUM_PAIRS = 8'(num_pairs(N_OUT));

  feeder_state_e            state;
  logic [7:0]               k;
  logic                     en_comp;
  logic                     rst_comp;
  logic                     trig;
  logic signed [DATA_W-1:0] in1;
  logic signed [DATA_W-1:0] in2;
  logic                     busy;
  logic                     done;

  logic                     buf_we;
  logic [7:0]               rd_addr_a;
  logic [7:0]               rd_addr_b;
  logic signed [DATA_W-1:0] rd_a;
  logic signed [DATA_W-1:0] rd_b;

  assign buf_we    = bus.wr_en && (state == ST_IDLE);
  assign rd_addr_a = k << 1;
  assign rd_addr_b = rd_addr_a | 8'd1;

  npu_result_buf #(
    .N_OUT  (N_OUT),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (CLKEXT),
    .we      (buf_we),
    .waddr   (bus.wr_addr),
    .wdata   (bus.wr_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Outputs are loaded on the edge that enters each state, so they line up
  // cycle-for-cycle with the state they describe.
  always_ff @(posedge CLKEXT or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      k        <= '0;
      en_comp  <= 1'b0;
      rst_comp <= 1'b0;
      trig     <= 1'b0;
      in1      <= NEG_MIN;
      in2      <= NEG_MIN;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rst_comp <= 1'b0;
      trig     <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          en_comp <= 1'b0;
          busy    <= 1'b0;
          if (bus.START) begin
            state    <= ST_CLEAR;
            k        <= '0;
            rst_comp <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Pair 0 leaves unconditionally: hold sampled during CLEAR is ignored.
          state   <= ST_FEED;
          en_comp <= 1'b1;
          trig    <= 1'b1;
          in1     <= rd_a;
          in2     <= rd_b;
          k       <= k + 8'd1;
        end
        ST_FEED: begin
          if (k == NUM_PAIRS) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end else if (!bus.hold) begin
            trig <= 1'b1;
            in1  <= rd_a;
            in2  <= rd_b;
            k    <= k + 8'd1;
          end
        end
        ST_FINISH: begin
          state   <= ST_IDLE;
          en_comp <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.EN_COMP  = en_comp;
  assign bus.RST_COMP = rst_comp;
  assign bus.trig     = trig;
  assign bus.in1      = in1;
  assign bus.in2      = in2;
  assign bus.busy     = busy;
  assign bus.DONE     = done;

endmodule

// File: tb/tb_argmax_pair_feeder.sv
// Self-checking bench: two feeders (N_OUT=10 and N_OUT=5) driving a behavioural
// strict-greater argmax comparator, checked against array-level argmax.
module tb_argmax_pair_feeder;
  import npu_pkg::*;

  localparam int NA = 10;
  localparam int NB = 5;
  localparam logic signed [15:0] NEG = 16'sh8000;

  typedef struct packed {
    logic en, rc, tg, bz, dn;
    logic [15:0] p1, p2;
  } obs_t;

  logic CLKEXT = 1'b0;
  logic RST;
  always #5 CLKEXT = ~CLKEXT;

  argmax_pair_feeder_if #(.DATA_W(16)) ia ();
  argmax_pair_feeder_if #(.DATA_W(16)) ib ();

  argmax_pair_feeder #(.N_OUT(NA), .DATA_W(16)) u_a (.CLKEXT(CLKEXT), .RST(RST), .bus(ia.slave));
  argmax_pair_feeder #(.N_OUT(NB), .DATA_W(16)) u_b (.CLKEXT(CLKEXT), .RST(RST), .bus(ib.slave));

  int n_run  = 0;
  int n_fail = 0;

  logic signed [15:0] ref_a [NA];
  logic signed [15:0] ref_b [NB];
  logic signed [15:0] got1 [$];
  logic signed [15:0] got2 [$];

  int done_cyc, n_done, n_rstc, rstc_cyc, bad_busy, bad_en, bad_stable, n_gap;
  logic signed [15:0] cmp_large;
  int cmp_idx;

  // ---------------- reference model ----------------
  function automatic int n_of(input int sel);
    return (sel == 0) ? NA : NB;
  endfunction

  function automatic logic signed [15:0] ref_get(input int sel, input int i);
    if (sel == 0) return (i < NA) ? ref_a[i] : NEG;
    return (i < NB) ? ref_b[i] : NEG;
  endfunction

  function automatic int ref_argmax(input int sel);
    int best = 0;
    for (int i = 0; i < n_of(sel); i++)
      if (best == 0 || ref_get(sel, i) > ref_get(sel, best - 1)) best = i + 1;
    return best;
  endfunction

  function automatic logic signed [15:0] ref_max(input int sel);
    return ref_get(sel, ref_argmax(sel) - 1);
  endfunction

  function automatic int pairs_bad(input int sel);
    int bad = 0;
    int np = (n_of(sel) + 1) / 2;
    if (got1.size() != np) return -1;
    for (int j = 0; j < np; j++)
      if (got1[j] !== ref_get(sel, 2 * j) || got2[j] !== ref_get(sel, 2 * j + 1)) bad++;
    return bad;
  endfunction

  // ---------------- drive / observe ----------------
  task automatic drive(input int sel, input logic we, input logic [7:0] a,
                       input logic signed [15:0] d, input logic st, input logic h);
    ia.wr_en = (sel == 0) & we; ia.wr_addr = a; ia.wr_data = d;
    ia.START = (sel == 0) & st; ia.hold = (sel == 0) & h;
    ib.wr_en = (sel == 1) & we; ib.wr_addr = a; ib.wr_data = d;
    ib.START = (sel == 1) & st; ib.hold = (sel == 1) & h;
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{ia.EN_COMP, ia.RST_COMP, ia.trig, ia.busy, ia.DONE, ia.in1, ia.in2};
    else          o = '{ib.EN_COMP, ib.RST_COMP, ib.trig, ib.busy, ib.DONE, ib.in1, ib.in2};
    return o;
  endfunction

  task automatic wr(input int sel, input logic [7:0] a, input logic signed [15:0] d);
    drive(sel, 1'b1, a, d, 1'b0, 1'b0);
    @(negedge CLKEXT);
    drive(sel, 1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
    if (sel == 0 && int'(a) < NA) ref_a[a] = d;
    if (sel == 1 && int'(a) < NB) ref_b[a] = d;
  endtask

  task automatic load_base();
    logic signed [15:0] base [NA] = '{3, -7, 12, 0, 5, 12, -1, 9, 2, 4};
    for (int i = 0; i < NA; i++) wr(0, 8'(i), base[i]);
  endtask

  // Runs one scan, feeding an attached comparator model and collecting observations.
  task automatic scan(input int sel, input int hold_at, input int hold_len, input int inj_cyc,
                      input logic sw, input logic [7:0] sw_addr, input logic signed [15:0] sw_data);
    obs_t o;
    int cyc;
    int cpos;
    logic signed [15:0] v1, v2;
    got1.delete(); got2.delete();
    done_cyc = -1; n_done = 0; n_rstc = 0; rstc_cyc = -1;
    bad_busy = 0; bad_en = 0; bad_stable = 0; n_gap = 0;
    cmp_large = NEG; cmp_idx = 0; cpos = 0;
    drive(sel, sw, sw_addr, sw_data, 1'b1, 1'b0);
    if (sw && sel == 0 && int'(sw_addr) < NA) ref_a[sw_addr] = sw_data;
    if (sw && sel == 1 && int'(sw_addr) < NB) ref_b[sw_addr] = sw_data;
    @(negedge CLKEXT);
    cyc = 1;
    forever begin
      o = obs(sel);
      v1 = o.p1; v2 = o.p2;
      if (o.rc) begin
        n_rstc++; rstc_cyc = cyc; cmp_large = NEG; cmp_idx = 0; cpos = 0;
      end
      if (o.tg) begin
        got1.push_back(v1); got2.push_back(v2);
        cpos += 2;
        if (v1 > cmp_large) begin cmp_large = v1; cmp_idx = cpos - 1; end
        if (v2 > cmp_large) begin cmp_large = v2; cmp_idx = cpos; end
      end else if (got1.size() > 0 && !o.dn) begin
        n_gap++;
        if (v1 !== got1[got1.size() - 1] || v2 !== got2[got2.size() - 1]) bad_stable++;
      end
      if (!o.bz) bad_busy++;
      if (((o.tg || o.dn) && !o.en) || (o.rc && o.en)) bad_en++;
      if (o.dn) begin n_done++; done_cyc = cyc; end
      if (o.dn || cyc >= 80) break;
      drive(sel, cyc == inj_cyc, 8'd0, 16'sd99, cyc == inj_cyc,
            cyc >= hold_at && cyc < hold_at + hold_len);
      @(negedge CLKEXT);
      cyc++;
    end
    drive(sel, 1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge CLKEXT);
      o = obs(sel);
      if (o.dn) n_done++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t o;
    RST = 1'b1;
    drive(0, 1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
    repeat (2) @(negedge CLKEXT);
    o = obs(0);
    n_run++; if (o.en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", o.en); end
    n_run++; if (o.rc !== 1'b0) begin n_fail++; $display("FAIL reset_rstcomp: got %b want 0", o.rc); end
    n_run++; if (o.tg !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", o.tg); end
    n_run++; if (o.p1 !== NEG) begin n_fail++; $display("FAIL reset_in1: got %h want 8000", o.p1); end
    n_run++; if (o.p2 !== NEG) begin n_fail++; $display("FAIL reset_in2: got %h want 8000", o.p2); end
    n_run++; if (o.bz !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o.bz); end
    n_run++; if (o.dn !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o.dn); end
    RST = 1'b0;
    @(negedge CLKEXT);
  endtask

  task automatic test_basic();
    obs_t o;
    load_base();
    scan(0, 0, 0, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (n_rstc !== 1 || rstc_cyc !== 1) begin n_fail++; $display("FAIL basic_rstcomp: got count %0d at cyc %0d want 1 at 1", n_rstc, rstc_cyc); end
    n_run++; if (got1.size() !== 5) begin n_fail++; $display("FAIL basic_trigs: got %0d want 5", got1.size()); end
    n_run++; if (pairs_bad(0) !== 0) begin n_fail++; $display("FAIL basic_pairs: got %0d bad want 0", pairs_bad(0)); end
    n_run++; if (done_cyc !== 7) begin n_fail++; $display("FAIL basic_latency: got %0d want 7", done_cyc); end
    n_run++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    n_run++; if (bad_busy !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d low cycles want 0", bad_busy); end
    n_run++; if (bad_en !== 0) begin n_fail++; $display("FAIL basic_en_comp: got %0d bad cycles want 0", bad_en); end
    n_run++; if (cmp_large !== 16'sd12 || cmp_idx !== 3) begin n_fail++; $display("FAIL basic_argmax: got %0d@%0d want 12@3", cmp_large, cmp_idx); end
    o = obs(0);
    n_run++; if (o.bz !== 1'b0 || o.en !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b en %b want 0 0", o.bz, o.en); end
  endtask

  task automatic test_odd();
    logic signed [15:0] vals [NB] = '{-5, -9, -2, -8, -3};
    for (int i = 0; i < NB; i++) wr(1, 8'(i), vals[i]);
    scan(1, 0, 0, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (got1.size() !== 3) begin n_fail++; $display("FAIL odd_trigs: got %0d want 3", got1.size()); end
    n_run++; if (pairs_bad(1) !== 0) begin n_fail++; $display("FAIL odd_pairs: got %0d bad want 0", pairs_bad(1)); end
    n_run++; if (got1.size() != 3 || got1[2] !== -16'sd3 || got2[2] !== NEG) begin n_fail++; $display("FAIL odd_pad: got last pair size %0d want (-3,8000)", got1.size()); end
    n_run++; if (done_cyc !== 5) begin n_fail++; $display("FAIL odd_latency: got %0d want 5", done_cyc); end
    n_run++; if (cmp_large !== -16'sd2 || cmp_idx !== 3) begin n_fail++; $display("FAIL odd_argmax: got %0d@%0d want -2@3", cmp_large, cmp_idx); end
  endtask

  task automatic test_hold();
    load_base();
    scan(0, 3, 2, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (n_gap !== 2) begin n_fail++; $display("FAIL hold_gap: got %0d want 2", n_gap); end
    n_run++; if (bad_stable !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d changes want 0", bad_stable); end
    n_run++; if (done_cyc !== 9) begin n_fail++; $display("FAIL hold_latency: got %0d want 9", done_cyc); end
    n_run++; if (pairs_bad(0) !== 0) begin n_fail++; $display("FAIL hold_pairs: got %0d bad want 0", pairs_bad(0)); end
    n_run++; if (cmp_large !== 16'sd12 || cmp_idx !== 3) begin n_fail++; $display("FAIL hold_argmax: got %0d@%0d want 12@3", cmp_large, cmp_idx); end
    scan(0, 1, 1, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (done_cyc !== 7 || n_gap !== 0) begin n_fail++; $display("FAIL hold_in_clear: got done %0d gap %0d want 7 0", done_cyc, n_gap); end
    scan(0, 6, 3, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (done_cyc !== 7 || got1.size() !== 5) begin n_fail++; $display("FAIL hold_after_last: got done %0d trigs %0d want 7 5", done_cyc, got1.size()); end
  endtask

  task automatic test_busy_inject();
    load_base();
    scan(0, 0, 0, 3, 1'b0, 8'd0, 16'sd0);
    n_run++; if (n_done !== 1 || done_cyc !== 7) begin n_fail++; $display("FAIL inject_done: got %0d dones at %0d want 1 at 7", n_done, done_cyc); end
    n_run++; if (cmp_large !== 16'sd12 || cmp_idx !== 3) begin n_fail++; $display("FAIL inject_argmax: got %0d@%0d want 12@3", cmp_large, cmp_idx); end
    scan(0, 0, 0, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (pairs_bad(0) !== 0) begin n_fail++; $display("FAIL inject_buffer: got %0d bad pairs want 0", pairs_bad(0)); end
    n_run++; if (cmp_large !== 16'sd12 || cmp_idx !== 3) begin n_fail++; $display("FAIL inject_rescan: got %0d@%0d want 12@3", cmp_large, cmp_idx); end
  endtask

  task automatic test_rst_mid();
    obs_t o;
    int stray;
    load_base();
    drive(0, 1'b0, 8'd0, 16'sd0, 1'b1, 1'b0);
    @(negedge CLKEXT);
    drive(0, 1'b0, 8'd0, 16'sd0, 1'b0, 1'b0);
    repeat (2) @(negedge CLKEXT);
    o = obs(0);
    n_run++; if (o.tg !== 1'b1 || o.bz !== 1'b1) begin n_fail++; $display("FAIL rst_prefeed: got trig %b busy %b want 1 1", o.tg, o.bz); end
    #2 RST = 1'b1;
    #1 o = obs(0);
    n_run++; if ({o.en, o.rc, o.tg, o.bz, o.dn} !== 5'b0) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 00000", {o.en, o.rc, o.tg, o.bz, o.dn}); end
    n_run++; if (o.p1 !== NEG || o.p2 !== NEG) begin n_fail++; $display("FAIL rst_async_data: got %h %h want 8000 8000", o.p1, o.p2); end
    repeat (2) @(negedge CLKEXT);
    RST = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge CLKEXT);
      o = obs(0);
      if (o.dn || o.bz || o.tg) stray++;
    end
    n_run++; if (stray !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d active cycles want 0", stray); end
    scan(0, 0, 0, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (done_cyc !== 7 || pairs_bad(0) !== 0) begin n_fail++; $display("FAIL rst_rescan: got done %0d bad %0d want 7 0", done_cyc, pairs_bad(0)); end
    n_run++; if (cmp_large !== 16'sd12 || cmp_idx !== 3) begin n_fail++; $display("FAIL rst_argmax: got %0d@%0d want 12@3", cmp_large, cmp_idx); end
  endtask

  task automatic test_wr_oob();
    for (int i = 0; i < NA; i++) wr(0, 8'(i), NEG);
    wr(0, 8'd4, 16'sd1);
    wr(0, 8'd10, 16'sd77);
    wr(0, 8'd255, 16'sd88);
    scan(0, 0, 0, 0, 1'b0, 8'd0, 16'sd0);
    n_run++; if (pairs_bad(0) !== 0) begin n_fail++; $display("FAIL oob_pairs: got %0d bad want 0", pairs_bad(0)); end
    n_run++; if (cmp_large !== 16'sd1 || cmp_idx !== 5) begin n_fail++; $display("FAIL oob_argmax: got %0d@%0d want 1@5", cmp_large, cmp_idx); end
  endtask

  task automatic test_start_with_write();
    load_base();
    scan(0, 0, 0, 0, 1'b1, 8'd9, 16'sd500);
    n_run++; if (pairs_bad(0) !== 0) begin n_fail++; $display("FAIL startwr_pairs: got %0d bad want 0", pairs_bad(0)); end
    n_run++; if (cmp_large !== 16'sd500 || cmp_idx !== 10) begin n_fail++; $display("FAIL startwr_argmax: got %0d@%0d want 500@10", cmp_large, cmp_idx); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int sel = it % 2;
      int n = n_of(sel);
      int np = (n + 1) / 2;
      int h_at, h_len;
      logic signed [15:0] v;
      for (int i = 0; i < n; i++) begin
        if (it < 4) v = 16'($urandom_range(0, 8)) - 16'sd4;
        else        v = 16'($urandom);
        wr(sel, 8'(i), v);
      end
      h_at  = $urandom_range(2, np);
      h_len = $urandom_range(0, 3);
      scan(sel, h_at, h_len, 0, 1'b0, 8'd0, 16'sd0);
      n_run++; if (pairs_bad(sel) !== 0) begin n_fail++; $display("FAIL rand%0d_pairs: got %0d bad want 0", it, pairs_bad(sel)); end
      n_run++; if (done_cyc !== 2 + np + h_len) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", it, done_cyc, 2 + np + h_len); end
      n_run++; if (cmp_large !== ref_max(sel) || cmp_idx !== ref_argmax(sel)) begin n_fail++; $display("FAIL rand%0d_argmax: got %0d@%0d want %0d@%0d", it, cmp_large, cmp_idx, ref_max(sel), ref_argmax(sel)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_hold();
    test_busy_inject();
    test_rst_mid();
    test_wr_oob();
    test_start_with_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
